// File: rtl/voice_pkg.sv
// Shared definitions for the voice-command digit path: token codes,
// controller state encoding and token classification.
package voice_pkg;

  localparam int VOICE_ID_W = 6;

  localparam int CMD_IDLE  = 0;
  localparam int CMD_START = 5;
  localparam int CMD_DONE  = 46;
  localparam int CMD_MORE  = 47;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } seq_state_e;

  typedef enum logic [2:0] {
    TOK_NONE,
    TOK_NUM,
    TOK_IDLE,
    TOK_START,
    TOK_DONE,
    TOK_MORE
  } tok_class_e;

  function automatic tok_class_e classify(input logic [31:0] v);
    if (v == 32'(CMD_IDLE))       return TOK_IDLE;
    else if (v == 32'(CMD_START)) return TOK_START;
    else if (v == 32'(CMD_DONE))  return TOK_DONE;
    else if (v == 32'(CMD_MORE))  return TOK_MORE;
    else                          return TOK_NUM;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell window counter; tick marks the last cycle of each window.
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic nRESET,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] LAST = W'(DWELL - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/voice_digit_sequencer.sv
// Records spoken number IDs between START and DONE, then loops them to the
// 7-segment encoder, one entry per dwell window, until the next command.
module voice_digit_sequencer
  import voice_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DWELL = 50_000_000,
  parameter int ID_W  = VOICE_ID_W
) (
  input  logic                     clk,
  input  logic                     nRESET,
  input  logic                     id_valid,
  input  logic [ID_W-1:0]          ID,
  output logic [ID_W-1:0]          disp_id,
  output logic                     disp_blank,
  output logic                     busy,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int RW = $clog2(DEPTH);
  localparam int CW = RW + 1;

  // Handshake: id_valid is a single-cycle strobe, no back-pressure; ID is
  // only looked at in a cycle where id_valid is high.
  seq_state_e      st_q;
  logic [CW-1:0]   count_q;
  logic [RW-1:0]   rd_q;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] disp_id_q;
  logic            disp_blank_q, busy_q, overflow_q;

  tok_class_e      tok;
  logic            full, wr_en, rd_last, dwell_clr, dwell_tick;
  logic [RW-1:0]   rd_next;

  assign tok       = id_valid ? classify(32'(ID)) : TOK_NONE;
  assign full      = (count_q == CW'(DEPTH));
  assign wr_en     = (st_q == ST_RECORD) && (tok == TOK_NUM) && !full;
  assign rd_last   = ({1'b0, rd_q} == count_q - CW'(1));
  assign rd_next   = rd_last ? '0 : rd_q + RW'(1);
  assign dwell_clr = (st_q != ST_PLAY);

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .nRESET (nRESET),
    .clr    (dwell_clr),
    .en     (1'b1),
    .tick   (dwell_tick)
  );

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[RW-1:0]] <= ID;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      st_q         <= ST_IDLE;
      count_q      <= '0;
      rd_q         <= '0;
      overflow_q   <= 1'b0;
      disp_id_q    <= '0;
      disp_blank_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (tok == TOK_START) begin
            st_q       <= ST_RECORD;
            count_q    <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RECORD: begin
          case (tok)
            TOK_NUM: begin
              if (!full) count_q    <= count_q + CW'(1);
              else       overflow_q <= 1'b1;
            end
            TOK_DONE: begin
              rd_q <= '0;
              if (count_q != '0) begin
                st_q         <= ST_PLAY;
                disp_id_q    <= mem_q[0];
                disp_blank_q <= 1'b0;
              end else begin
                st_q   <= ST_IDLE;
                busy_q <= 1'b0;
              end
            end
            TOK_START: begin
              count_q    <= '0;
              overflow_q <= 1'b0;
            end
            TOK_IDLE: begin
              st_q    <= ST_IDLE;
              count_q <= '0;
              rd_q    <= '0;
              busy_q  <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_PLAY: begin
          // An acting command preempts a coincident dwell expiry.
          case (tok)
            TOK_MORE: begin
              st_q         <= ST_RECORD;
              disp_id_q    <= '0;
              disp_blank_q <= 1'b1;
            end
            TOK_START: begin
              st_q         <= ST_RECORD;
              count_q      <= '0;
              rd_q         <= '0;
              overflow_q   <= 1'b0;
              disp_id_q    <= '0;
              disp_blank_q <= 1'b1;
            end
            TOK_IDLE: begin
              st_q         <= ST_IDLE;
              count_q      <= '0;
              rd_q         <= '0;
              busy_q       <= 1'b0;
              disp_id_q    <= '0;
              disp_blank_q <= 1'b1;
            end
            default: begin
              if (dwell_tick) begin
                rd_q      <= rd_next;
                disp_id_q <= mem_q[rd_next];
              end
            end
          endcase
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign disp_id    = disp_id_q;
  assign disp_blank = disp_blank_q;
  assign busy       = busy_q;
  assign state      = st_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_voice_digit_sequencer.sv
// Bench for voice_digit_sequencer with DEPTH=4, DWELL=4: recorded IDs are
// modelled in a small queue and the expected display stream is scoreboarded.
module tb_voice_digit_sequencer;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int ID_W  = 6;

  logic            clk = 1'b0;
  logic            nRESET;
  logic            id_valid;
  logic [ID_W-1:0] ID;
  logic [ID_W-1:0] disp_id;
  logic            disp_blank;
  logic            busy;
  logic [1:0]      state;
  logic [2:0]      count;
  logic            overflow;

  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] model_q[$];
  logic            model_ovf;
  int              n_cmp = 0;
  int              n_err = 0;

  voice_digit_sequencer #(.DEPTH(DEPTH), .DWELL(DWELL), .ID_W(ID_W)) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .id_valid   (id_valid),
    .ID         (ID),
    .disp_id    (disp_id),
    .disp_blank (disp_blank),
    .busy       (busy),
    .state      (state),
    .count      (count),
    .overflow   (overflow)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send_tok(input logic [ID_W-1:0] tok);
    @(posedge clk); #1;
    id_valid = 1'b1;
    ID       = tok;
    @(posedge clk); #1;
    id_valid = 1'b0;
    ID       = ID_W'($urandom_range(0, 63));
  endtask

  task automatic start_session();
    send_tok(6'd5);
    model_q.delete();
    model_ovf = 1'b0;
    check_eq("start_state", 32'(state), 32'd1);
    check_eq("start_count", 32'(count), 32'd0);
    check_eq("start_ovf",   32'(overflow), 32'd0);
    check_eq("start_busy",  32'(busy), 32'd1);
  endtask

  task automatic add_num(input logic [ID_W-1:0] id);
    send_tok(id);
    if (model_q.size() < DEPTH) model_q.push_back(id);
    else                        model_ovf = 1'b1;
    check_eq("rec_count", 32'(count), 32'(model_q.size()));
    check_eq("rec_ovf",   32'(overflow), 32'(model_ovf));
  endtask

  task automatic send_done();
    send_tok(6'd46);
    for (int i = 0; i < 4 * DWELL * DEPTH; i++)
      exp_q.push_back(model_q[(i / DWELL) % model_q.size()]);
    check_eq("done_state", 32'(state), 32'd2);
    check_eq("done_busy",  32'(busy), 32'd1);
  endtask

  // scoreboard: one expected ID popped per displayed cycle
  task automatic play_check(input int cycles);
    logic [ID_W-1:0] e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq("play_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("play_disp_id", 32'(disp_id), 32'(e));
        check_eq("play_blank", 32'(disp_blank), 32'd0);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_blank"}, 32'(disp_blank), 32'd1);
    check_eq({tag, "_disp"},  32'(disp_id), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    nRESET   = 1'b0;
    id_valid = 1'b0;
    ID       = '0;
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    nRESET = 1'b1;

    // 1: a number with no session is ignored
    send_tok(6'd13);
    check_idle_outputs("ignore_num");

    // 2: record three IDs and loop them
    start_session();
    add_num(6'd13);
    add_num(6'd35);
    add_num(6'd44);
    send_done();
    play_check(3 * DWELL + 2);

    // 3: append with overflow
    send_tok(6'd47);
    check_eq("more_state", 32'(state), 32'd1);
    check_eq("more_count", 32'(count), 32'd3);
    check_eq("more_blank", 32'(disp_blank), 32'd1);
    add_num(6'd30);
    add_num(6'd38);
    send_done();
    check_eq("play_ovf", 32'(overflow), 32'd1);
    play_check(4 * DWELL + 3);

    // 4: empty session returns to IDLE
    start_session();
    send_tok(6'd46);
    check_idle_outputs("empty_done");

    // 5: IDLE coincident with dwell expiry
    start_session();
    add_num(6'd13);
    add_num(6'd35);
    send_done();
    play_check(DWELL - 1);
    send_tok(6'd0);
    check_idle_outputs("idle_on_tick");

    // 6: asynchronous reset mid-PLAY
    start_session();
    add_num(6'd21);
    add_num(6'd22);
    send_done();
    play_check(DWELL + 2);
    @(negedge clk);
    #1 nRESET = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check_eq("async_rst_ovf", 32'(overflow), 32'd0);
    #2 nRESET = 1'b1;
    start_session();
    add_num(6'd42);
    send_done();
    play_check(3 * DWELL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_digit_sequencer.md
# voice_digit_sequencer

Controller between the voice-command ID stream and the 7-segment digit encoder. It decodes command IDs (0 idle, 5 start, 46 done, 47 more) and buffers the number IDs spoken during a session. It then plays the buffered IDs back one at a time to the display encoder with a programmable dwell time, looping until the next command. It replaces direct ID-to-display wiring in the top level.

## Interface
- DEPTH, 8: number of ID entries buffered (power of 2, ≥2)
- DWELL, 50_000_000: clock cycles each buffered ID is shown (≥1)
- ID_W, 6: ID width

- clk  in  1  system clock
- nRESET  in  1  asynchronous, active-low reset
- id_valid  in  1  one-cycle strobe: ID holds a new token
- ID  in  ID_W  voice token; sampled only when id_valid=1
- disp_id  out  ID_W  ID presented to the 7-segment encoder
- disp_blank  out  1  1 = encoder must blank the display
- busy  out  1  1 in RECORD or PLAY
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY
- count  out  $clog2(DEPTH)+1  entries currently buffered
- overflow  out  1  sticky: a number token was dropped because the buffer was full

## Operation
- Token classes: CMD_IDLE=0, CMD_START=5, CMD_DONE=46, CMD_MORE=47. Any other value is a NUMBER.
- Buffer: DEPTH×ID_W register array with write index = count. Play index rd in 0..count-1.
- IDLE:
  - START → RECORD, with count, rd, dwell and overflow cleared.
  - All other tokens are ignored.
- RECORD:
  - NUMBER with count<DEPTH: write at buf[count], then count+1.
  - NUMBER with count==DEPTH: drop it and set overflow.
  - DONE: go to PLAY if count>0, otherwise go to IDLE. rd and dwell are cleared.
  - START: stay in RECORD, with count and overflow cleared.
  - IDLE: go to IDLE, with count cleared.
  - MORE: ignored.
- PLAY:
  - disp_id=buf[rd]. The dwell counter runs 0..DWELL-1.
  - At DWELL-1, rd advances, wrapping from count-1 to 0, and dwell returns to 0. With count=1, rd stays at 0.
  - MORE: go to RECORD keeping existing entries, so new NUMBERs append.
  - START: go to RECORD cleared.
  - IDLE: go to IDLE cleared.
  - NUMBER and DONE: ignored.
- disp_blank=1 and disp_id=0 outside PLAY.
- Widths:
  - count saturates at DEPTH.
  - The dwell counter is $clog2(DWELL) bits wide (minimum 1).
  - No arithmetic wraps silently.

## Timing
- Reset (async assert, sync-released by the top level) values:
  - state=IDLE, count=0, rd=0, dwell=0, overflow=0
  - disp_id=0, disp_blank=1, busy=0
  - Buffer contents are don't-care.
- All outputs are registered. A token strobed at edge k takes effect on outputs after edge k (visible in cycle k+1).
- DONE→PLAY:
  - buf[0] appears on disp_id with disp_blank=0 in the cycle after DONE is sampled.
  - Each entry is shown for exactly DWELL cycles.
- A command strobe in the same cycle as dwell expiry: the command wins, and rd does not advance.
- A NUMBER written in the same edge as DONE is not possible, since there is one token per strobe.
- MORE→RECORD→DONE: playback restarts at rd=0 with the full appended buffer.
- Reset mid-PLAY or mid-RECORD: immediate return to reset values, with no partial-state retention.

## Structure
- Shared package voice_pkg:
  - CMD_IDLE, CMD_START, CMD_DONE, CMD_MORE constants
  - 2-bit state encoding localparams
  - ID_W default
- One sub-module is natural: dwell_timer (parameter DWELL; ports clk, nRESET, clr, en, tick). tick pulses on the last cycle of each dwell window.
- Buffer, index logic and FSM live in voice_digit_sequencer. The encoder is instantiated outside it, in Top.

## Test plan
All scenarios use DWELL=4 and DEPTH=4.
1. Reset, then ID 13 with no START → state=IDLE, count=0, disp_blank=1.
2. START, 13, 35, 44, DONE:
   - disp_id sequence is 13×4, 35×4, 44×4, 13… (loops).
   - busy=1, disp_blank=0 from the cycle after DONE.
3. From PLAY: MORE, 30, 38, DONE → count=5 is blocked at DEPTH=4. Expected result: count=4, overflow=1, playback 13, 35, 44, 30.
4. START then immediately DONE (count=0) → state returns to IDLE, disp_blank stays 1.
5. IDLE strobe on the same edge as dwell expiry in PLAY → state=IDLE next cycle, disp_id=0, count=0, no rd advance observed.
6. nRESET pulsed low for 3 ns mid-PLAY, asynchronous to clk → all outputs at reset values before the next clk edge. A subsequent START/42/DONE plays only 42.
